sensor_hub_mux: RTL and testbench

- Parametrised successor to the fixed three-way FND/TX selection in the sensor/clock top level.
- Multiplexes NUM_CH sensor/clock channels onto one 4-digit FND and one UART byte stream.
- Selects the displayed channel by direct load, next-button step or automatic rotation.
- Routes a single start pulse to the selected channel and arbitrates UART bytes between channels round-robin with packet locking and a stall timeout.

---
 rtl/sensor_hub_mux.sv | 203 ++++++++++++++++++++
 tb/tb_sensor_hub_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_hub_mux.sv
// sensor_hub_mux: NUM_CH sensor/clock channels onto one FND and one UART.
// Selection by load/next/auto-rotate; round-robin packet-locked TX arbiter.
module sensor_hub_mux #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int AUTO_PERIOD = 200_000_000,
  parameter int TX_TIMEOUT  = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH_W-1:0]     i_sel,
  input  logic                i_sel_load,
  input  logic                i_next,
  input  logic                i_auto_en,
  input  logic                i_start,
  output logic [NUM_CH-1:0]   o_start,
  input  logic [NUM_CH*8-1:0] i_fnd_data,
  input  logic [NUM_CH*4-1:0] i_fnd_com,
  output logic [7:0]          o_fnd_data,
  output logic [3:0]          o_fnd_com,
  output logic [CH_W-1:0]     o_sel,
  input  logic [NUM_CH-1:0]   i_tx_valid,
  input  logic [NUM_CH*8-1:0] i_tx_data,
  input  logic [NUM_CH-1:0]   i_tx_last,
  output logic [NUM_CH-1:0]   o_tx_ready,
  output logic                o_uart_valid,
  output logic [7:0]          o_uart_data,
  input  logic                i_uart_ready,
  output logic [NUM_CH-1:0]   o_grant
);

  localparam int AW = $clog2(AUTO_PERIOD + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam logic [CH_W-1:0] LP_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   LP_NUM  = (CH_W+1)'(NUM_CH);
  localparam logic [AW-1:0]   LP_AEND = AW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0]   LP_TEND = TW'(TX_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } tx_state_t;

  logic [CH_W-1:0]   r_sel;
  logic [AW-1:0]     r_auto_cnt;
  logic [7:0]        r_fnd_data;
  logic [3:0]        r_fnd_com;
  logic [NUM_CH-1:0] r_start;

  tx_state_t         r_state;
  logic [CH_W-1:0]   r_owner;
  logic [CH_W-1:0]   r_last;
  logic [NUM_CH-1:0] r_grant;
  logic [TW-1:0]     r_stall;

  logic              w_load_ok;
  logic [CH_W-1:0]   w_sel_nxt;
  logic [NUM_CH-1:0] w_sel_oh;
  logic [7:0]        w_fnd_data;
  logic [3:0]        w_fnd_com;

  logic              w_pick_ok;
  logic [CH_W-1:0]   w_pick;
  logic [NUM_CH-1:0] w_pick_oh;
  logic [CH_W:0]     w_sum;
  logic              w_lock;
  logic              w_own_valid;
  logic              w_own_last;
  logic [7:0]        w_own_data;
  logic              w_xfer;

  assign w_load_ok = i_sel_load && ({1'b0, i_sel} < LP_NUM);
  // Wrap at NUM_CH-1 so non-power-of-two counts never visit unused codes
  assign w_sel_nxt = (r_sel == LP_LAST) ? '0 : r_sel + CH_W'(1);

  always_comb begin
    w_sel_oh   = '0;
    w_fnd_data = 8'hFF;
    w_fnd_com  = 4'hF;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_sel == CH_W'(k)) begin
        w_sel_oh[k] = 1'b1;
        w_fnd_data  = i_fnd_data[8*k +: 8];
        w_fnd_com   = i_fnd_com[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel      <= '0;
      r_auto_cnt <= '0;
    end else if (w_load_ok) begin
      r_sel      <= i_sel;
      r_auto_cnt <= '0;
    end else if (i_next) begin
      r_sel      <= w_sel_nxt;
      r_auto_cnt <= '0;
    end else if (!i_auto_en) begin
      r_auto_cnt <= '0;
    end else if (r_auto_cnt == LP_AEND) begin
      r_sel      <= w_sel_nxt;
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AW'(1);
    end
  end

  // Display and start both use the pre-update selection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fnd_data <= 8'hFF;
      r_fnd_com  <= 4'hF;
      r_start    <= '0;
    end else begin
      r_fnd_data <= w_fnd_data;
      r_fnd_com  <= w_fnd_com;
      r_start    <= i_start ? w_sel_oh : '0;
    end
  end

  // Walk downward so the first requester after r_last wins
  always_comb begin
    w_pick_ok = 1'b0;
    w_pick    = '0;
    w_sum     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_sum = {1'b0, r_last} + (CH_W+1)'(i);
      if (w_sum >= LP_NUM) w_sum = w_sum - LP_NUM;
      if (i_tx_valid[w_sum[CH_W-1:0]]) begin
        w_pick_ok = 1'b1;
        w_pick    = w_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_pick_oh   = '0;
    w_own_data  = '0;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_pick_oh[k] = (w_pick == CH_W'(k));
      if (r_owner == CH_W'(k)) begin
        w_own_data  = i_tx_data[8*k +: 8];
        w_own_valid = i_tx_valid[k];
        w_own_last  = i_tx_last[k];
      end
    end
  end

  assign w_lock = (r_state == ST_LOCK);
  assign w_xfer = w_lock && w_own_valid && i_uart_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= LP_LAST;
      r_grant <= '0;
      r_stall <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_stall <= '0;
          if (w_pick_ok) begin
            r_owner <= w_pick;
            r_grant <= w_pick_oh;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer && w_own_last) begin
            r_last  <= r_owner;
            r_grant <= '0;
            r_stall <= '0;
            r_state <= ST_IDLE;
          end else if (w_own_valid) begin
            r_stall <= '0;
          end else if (r_stall == LP_TEND) begin
            r_last  <= r_owner;
            r_grant <= '0;
            r_stall <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_stall <= r_stall + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel        = r_sel;
  assign o_fnd_data   = r_fnd_data;
  assign o_fnd_com    = r_fnd_com;
  assign o_start      = r_start;
  assign o_grant      = r_grant;
  assign o_uart_valid = w_lock && w_own_valid;
  assign o_uart_data  = o_uart_valid ? w_own_data : 8'h00;
  assign o_tx_ready   = (w_lock && i_uart_ready) ? r_grant : '0;

endmodule

// File: tb/tb_sensor_hub_mux.sv
// tb_sensor_hub_mux: directed steps with a byte scoreboard on the UART side.
// A second 3-channel instance covers non-power-of-two wrap.
module tb_sensor_hub_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  sel;
  logic        sel_load, nxt, auto_en, start;
  logic [3:0]  o_start;
  logic [31:0] fnd_data;
  logic [15:0] fnd_com;
  logic [7:0]  o_fnd_data;
  logic [3:0]  o_fnd_com;
  logic [1:0]  o_sel;
  logic [3:0]  tx_valid, tx_last, tx_ready, grant;
  logic [31:0] tx_data;
  logic        uart_valid, uart_ready;
  logic [7:0]  uart_data;

  logic [1:0]  sel3;
  logic        load3, next3;
  logic [2:0]  d3_start, d3_tx_ready, d3_grant;
  logic [7:0]  d3_fnd_data, d3_ud;
  logic [3:0]  d3_fnd_com;
  logic [1:0]  d3_sel;
  logic        d3_uv;

  sensor_hub_mux #(
    .NUM_CH(4), .CH_W(2), .AUTO_PERIOD(10), .TX_TIMEOUT(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .i_sel(sel), .i_sel_load(sel_load), .i_next(nxt),
    .i_auto_en(auto_en), .i_start(start), .o_start(o_start),
    .i_fnd_data(fnd_data), .i_fnd_com(fnd_com),
    .o_fnd_data(o_fnd_data), .o_fnd_com(o_fnd_com), .o_sel(o_sel),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .i_tx_last(tx_last),
    .o_tx_ready(tx_ready), .o_uart_valid(uart_valid),
    .o_uart_data(uart_data), .i_uart_ready(uart_ready), .o_grant(grant)
  );

  sensor_hub_mux #(
    .NUM_CH(3), .CH_W(2), .AUTO_PERIOD(10), .TX_TIMEOUT(8)
  ) u_dut3 (
    .clk(clk), .reset(reset),
    .i_sel(sel3), .i_sel_load(load3), .i_next(next3),
    .i_auto_en(1'b0), .i_start(1'b0), .o_start(d3_start),
    .i_fnd_data(24'h0), .i_fnd_com(12'h0),
    .o_fnd_data(d3_fnd_data), .o_fnd_com(d3_fnd_com), .o_sel(d3_sel),
    .i_tx_valid(3'b0), .i_tx_data(24'h0), .i_tx_last(3'b0),
    .o_tx_ready(d3_tx_ready), .o_uart_valid(d3_uv),
    .o_uart_data(d3_ud), .i_uart_ready(1'b0), .o_grant(d3_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  src_q [4][$];
  logic [11:0] exp_q [$];
  logic [3:0]  hs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    for (int c = 0; c < 4; c++) begin
      if (src_q[c].size() > 0) begin
        tx_valid[c]        = 1'b1;
        tx_data[c*8 +: 8]  = src_q[c][0][7:0];
        tx_last[c]         = src_q[c][0][8];
      end else begin
        tx_valid[c]        = 1'b0;
        tx_data[c*8 +: 8]  = 8'h00;
        tx_last[c]         = 1'b0;
      end
    end
  endtask

  task automatic send(input int c, input logic [7:0] d, input logic l);
    src_q[c].push_back({l, d});
    drive_src();
  endtask

  task automatic expect_byte(input logic [3:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Source model: a byte leaves its queue after a valid&ready edge
  always @(negedge clk) hs = reset ? 4'b0 : (tx_ready & tx_valid);

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 4; c++)
      if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    drive_src();
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset) begin
      if (uart_valid && uart_ready) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed=%0h expected=none",
                 {grant, uart_data});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_byte", {grant, uart_data}, e);
        end
      end
      if (!uart_valid) chk("data_zero", uart_data, 8'h00);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = '0; sel_load = 0; nxt = 0; auto_en = 0;
    start = 0; uart_ready = 1'b1;
    sel3 = '0; load3 = 0; next3 = 0;
    fnd_data = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    fnd_com  = {4'h7, 4'hB, 4'hD, 4'hE};
    drive_src();
    tick(); tick();
    chk("rst_fnd_data", o_fnd_data, 8'hFF);
    chk("rst_fnd_com", o_fnd_com, 4'hF);
    chk("rst_sel", o_sel, 2'd0);
    chk("rst_start", o_start, 4'h0);
    chk("rst_grant", grant, 4'h0);
    chk("rst_uvalid", uart_valid, 1'b0);
    chk("rst_ready", tx_ready, 4'h0);
    chk("rst_sel3", d3_sel, 2'd0);

    reset = 1'b0;
    chk("fnd_pre_edge", o_fnd_data, 8'hFF);
    tick();
    chk("fnd_ch0", o_fnd_data, 8'hC0);
    chk("com_ch0", o_fnd_com, 4'hE);
    nxt = 1; tick(); nxt = 0;
    chk("next_sel", o_sel, 2'd1);
    chk("fnd_lag", o_fnd_data, 8'hC0);
    tick();
    chk("fnd_ch1", o_fnd_data, 8'hF9);
    chk("com_ch1", o_fnd_com, 4'hD);

    sel = 2'd3; sel_load = 1; tick(); sel_load = 0;
    chk("load3", o_sel, 2'd3);
    nxt = 1; tick(); nxt = 0;
    chk("wrap4", o_sel, 2'd0);

    for (int i = 0; i < 3; i++) begin
      next3 = 1; tick(); next3 = 0;
      chk("n3_step", d3_sel, (i + 1) % 3);
    end
    sel3 = 2'd3; load3 = 1; tick(); load3 = 0;
    chk("n3_load_oob", d3_sel, 2'd0);
    sel3 = 2'd2; load3 = 1; next3 = 1; tick(); load3 = 0; next3 = 0;
    chk("n3_load_pri", d3_sel, 2'd2);
    next3 = 1; tick(); next3 = 0;
    chk("n3_wrap", d3_sel, 2'd0);

    auto_en = 1;
    repeat (9) tick();
    chk("auto_hold", o_sel, 2'd0);
    tick();
    chk("auto_step1", o_sel, 2'd1);
    repeat (4) tick();
    nxt = 1; tick(); nxt = 0;
    chk("auto_manual", o_sel, 2'd2);
    repeat (9) tick();
    chk("auto_restart", o_sel, 2'd2);
    tick();
    chk("auto_step2", o_sel, 2'd3);
    auto_en = 0;
    repeat (25) tick();
    chk("auto_off", o_sel, 2'd3);

    sel = 2'd2; sel_load = 1; tick(); sel_load = 0;
    chk("start_sel", o_sel, 2'd2);
    start = 1; tick(); start = 0;
    chk("start_pulse", o_start, 4'b0100);
    tick();
    chk("start_width", o_start, 4'b0000);
    start = 1; nxt = 1; tick(); start = 0; nxt = 0;
    chk("start_old", o_start, 4'b0100);
    chk("start_sel_new", o_sel, 2'd3);

    expect_byte(4'b0010, 8'h41);
    expect_byte(4'b0010, 8'h42);
    expect_byte(4'b0010, 8'h43);
    expect_byte(4'b0100, 8'h51);
    expect_byte(4'b0100, 8'h52);
    send(1, 8'h41, 0); send(1, 8'h42, 0); send(1, 8'h43, 1);
    send(2, 8'h51, 0); send(2, 8'h52, 1);
    tick();
    chk("rr_grant1", grant, 4'b0010);
    chk("rr_ready1", tx_ready, 4'b0010);
    chk("rr_uvalid", uart_valid, 1'b1);
    tick(); tick(); tick();
    chk("rr_gap", grant, 4'b0000);
    chk("rr_gap_uv", uart_valid, 1'b0);
    tick();
    chk("rr_grant2", grant, 4'b0100);
    wait_drain(50);

    reset = 1;
    expect_byte(4'b0001, 8'hA0);
    expect_byte(4'b0010, 8'hA1);
    expect_byte(4'b1000, 8'hA3);
    send(3, 8'hA3, 1); send(1, 8'hA1, 1); send(0, 8'hA0, 1);
    tick(); tick();
    reset = 0;
    tick();
    chk("prio_ch0", grant, 4'b0001);
    wait_drain(50);

    expect_byte(4'b0001, 8'h61);
    expect_byte(4'b0010, 8'h71);
    send(0, 8'h61, 0); send(1, 8'h71, 1);
    tick();
    chk("to_grant", grant, 4'b0001);
    tick();
    repeat (7) tick();
    chk("to_hold", grant, 4'b0001);
    tick();
    chk("to_release", grant, 4'b0000);
    tick();
    chk("to_next", grant, 4'b0010);
    wait_drain(50);

    uart_ready = 0;
    send(0, 8'h81, 0);
    tick();
    chk("mid_grant", grant, 4'b0001);
    chk("mid_uvalid", uart_valid, 1'b1);
    chk("mid_udata", uart_data, 8'h81);
    reset = 1;
    tick();
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_uv", uart_valid, 1'b0);
    chk("mid_rst_ready", tx_ready, 4'b0000);
    chk("mid_rst_sel", o_sel, 2'd0);
    for (int c = 0; c < 4; c++) src_q[c].delete();
    drive_src();
    uart_ready = 1;
    tick();
    reset = 0;
    tick(); tick();
    chk("post_idle", grant, 4'b0000);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
